// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: blank pattern, segment bit
// positions and the BCD-to-segment decoder used by display blocks.
package seg7_pkg;

   localparam logic [6:0] SEG7_BLANK = 7'b000_0000;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // Pattern literals are written g..a; they are mapped onto the
   // segment positions so a board with a different pinout only
   // needs the index constants changed.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
      logic [6:0] pat;
      logic [6:0] seg;
      case (bcd)
         4'd0:    pat = 7'b011_1111;
         4'd1:    pat = 7'b000_0110;
         4'd2:    pat = 7'b101_1011;
         4'd3:    pat = 7'b100_1111;
         4'd4:    pat = 7'b110_0110;
         4'd5:    pat = 7'b110_1101;
         4'd6:    pat = 7'b111_1101;
         4'd7:    pat = 7'b000_0111;
         4'd8:    pat = 7'b111_1111;
         4'd9:    pat = 7'b110_1111;
         default: pat = SEG7_BLANK;
      endcase
      seg        = SEG7_BLANK;
      seg[SEG_A] = pat[0];
      seg[SEG_B] = pat[1];
      seg[SEG_C] = pat[2];
      seg[SEG_D] = pat[3];
      seg[SEG_E] = pat[4];
      seg[SEG_F] = pat[5];
      seg[SEG_G] = pat[6];
      return seg;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One up/down BCD decade with synchronous clear.
// term_o flags 9 (counting up) or 0 (counting down).
module bcd_digit (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       step_i,
   input  logic       up_down_i,
   input  logic       clear_i,
   output logic [3:0] value_o,
   output logic       term_o
);

   logic [3:0] value_q;
   logic [3:0] value_d;

   // Next value: clear wins, otherwise step up or down with wrap.
   always_comb begin
      value_d = value_q;
      if (clear_i) begin
         value_d = 4'd0;
      end else if (step_i) begin
         if (up_down_i) begin
            value_d = (value_q == 4'd9) ? 4'd0 : value_q + 4'd1;
         end else begin
            value_d = (value_q == 4'd0) ? 4'd9 : value_q - 4'd1;
         end
      end
   end

   // Decade register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) value_q <= 4'd0;
      else       value_q <= value_d;
   end

   assign value_o = value_q;
   assign term_o  = up_down_i ? (value_q == 4'd9)
                              : (value_q == 4'd0);

endmodule

// File: rtl/seven_segment_mux_counter.sv
// Multi-digit BCD counter with multiplexed seven-segment scan.
// Define SEG7_BLANK_EN to blank leading zero digits.
module seven_segment_mux_counter
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_COUNT = 16_000_000,
   parameter int SCAN_COUNT = 16_000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    clear,
   input  logic                    up_down,
   output logic [6:0]              led_out,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic                    carry_out
);

   localparam int PW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
   localparam int SW = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_COUNT - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_COUNT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]         presc_q, presc_d;
   logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
   logic [IW-1:0]         scan_idx_q, scan_idx_d;
   logic                  carry_q, carry_d;
   logic [6:0]            led_q, led_d;
   logic [NUM_DIGITS-1:0] sel_q, sel_d;
   logic                  tick;
   logic [NUM_DIGITS:0]   step;
   logic [NUM_DIGITS-1:0] term;
   logic [3:0]            cur_dig;
   logic                  blank;

   // Count prescaler: advances while enabled, clear restarts it.
   always_comb begin
      tick    = enable & (presc_q == TICK_LAST);
      presc_d = presc_q;
      if (clear) begin
         presc_d = '0;
      end else if (enable) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
      end
   end

   // Ripple the tick up through decades sitting at their terminal.
   assign step[0] = tick;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
      bcd_digit u_dig (
         .clk_i     (clk),
         .rst_i     (reset),
         .step_i    (step[i]),
         .up_down_i (up_down),
         .clear_i   (clear),
         .value_o   (bcd_out[4*i +: 4]),
         .term_o    (term[i])
      );
      assign step[i+1] = step[i] & term[i];
   end

   // A step leaving the top decade is a full wrap.
   assign carry_d = step[NUM_DIGITS] & ~clear;

   // Free-running scan timer and digit index.
   always_comb begin
      scan_cnt_d = scan_cnt_q + SW'(1);
      scan_idx_d = scan_idx_q;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         scan_idx_d = (scan_idx_q == IDX_LAST) ? '0
                                               : scan_idx_q + IW'(1);
      end
   end

   // Select the scanned digit and decide whether it is a leading zero.
   always_comb begin
      cur_dig = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (scan_idx_q == IW'(i)) cur_dig = bcd_out[4*i +: 4];
      end
      blank = 1'b0;
`ifdef SEG7_BLANK_EN
      begin
         logic zero_run;
         zero_run = 1'b1;
         for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run & (bcd_out[4*i +: 4] == 4'd0);
            if (scan_idx_q == IW'(i) && zero_run) blank = 1'b1;
         end
      end
`endif
      led_d = blank ? SEG7_BLANK : bcd_to_seg(cur_dig);
      sel_d = NUM_DIGITS'(1) << scan_idx_q;
   end

   // State and registered display outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q    <= '0;
         scan_cnt_q <= '0;
         scan_idx_q <= '0;
         carry_q    <= 1'b0;
         led_q      <= SEG7_BLANK;
         sel_q      <= NUM_DIGITS'(1);
      end else begin
         presc_q    <= presc_d;
         scan_cnt_q <= scan_cnt_d;
         scan_idx_q <= scan_idx_d;
         carry_q    <= carry_d;
         led_q      <= led_d;
         sel_q      <= sel_d;
      end
   end

   assign led_out   = led_q;
   assign digit_sel = sel_q;
   assign carry_out = carry_q;

endmodule

// File: tb/tb_seven_segment_mux_counter.sv
// Scoreboard bench for seven_segment_mux_counter
// (NUM_DIGITS=2, TICK_COUNT=4, SCAN_COUNT=2).
module tb_seven_segment_mux_counter;

   typedef struct packed {
      logic [7:0] bcd;
      logic       carry;
      logic [1:0] sel;
      logic [6:0] led;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       clear;
   logic       up_down;
   logic [6:0] led_out;
   logic [1:0] digit_sel;
   logic [7:0] bcd_out;
   logic       carry_out;

   int n_checks;
   int n_errors;

   exp_t sb_q[$];

   int m_cnt;
   int m_presc;
   int m_scnt;
   int m_idx;

   logic [6:0] seg_tab [10];

   seven_segment_mux_counter #(
      .NUM_DIGITS (2),
      .TICK_COUNT (4),
      .SCAN_COUNT (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .clear     (clear),
      .up_down   (up_down),
      .led_out   (led_out),
      .digit_sel (digit_sel),
      .bcd_out   (bcd_out),
      .carry_out (carry_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic compare_out(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      chk({tag, "_bcd"},   32'(bcd_out),   32'(e.bcd));
      chk({tag, "_carry"}, 32'(carry_out), 32'(e.carry));
      chk({tag, "_sel"},   32'(digit_sel), 32'(e.sel));
      chk({tag, "_led"},   32'(led_out),   32'(e.led));
   endtask

   task automatic model_reset();
      m_cnt   = 0;
      m_presc = 0;
      m_scnt  = 0;
      m_idx   = 0;
   endtask

   // One clock: predict, push, clock, pop and compare.
   task automatic cyc();
      exp_t e;
      bit   tk;
      int   nc;
      int   np;
      int   d;
      tk = !clear && enable && (m_presc == 3);
      if (clear)       np = 0;
      else if (enable) np = (m_presc == 3) ? 0 : m_presc + 1;
      else             np = m_presc;
      if (clear)        nc = 0;
      else if (!tk)     nc = m_cnt;
      else if (up_down) nc = (m_cnt + 1) % 100;
      else              nc = (m_cnt + 99) % 100;
      e.carry = tk && (up_down ? (m_cnt == 99) : (m_cnt == 0));
      e.sel   = (m_idx == 0) ? 2'b01 : 2'b10;
      d       = (m_idx == 0) ? (m_cnt % 10) : (m_cnt / 10);
      e.led   = seg_tab[d];
`ifdef SEG7_BLANK_EN
      if (m_idx == 1 && (m_cnt / 10) == 0) e.led = 7'b000_0000;
`endif
      e.bcd = {4'(nc / 10), 4'(nc % 10)};
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      compare_out("cyc");
      m_cnt   = nc;
      m_presc = np;
      if (m_scnt == 1) begin
         m_scnt = 0;
         m_idx  = 1 - m_idx;
      end else begin
         m_scnt = m_scnt + 1;
      end
   endtask

   task automatic push_reset_exp();
      exp_t e;
      e.bcd   = 8'h00;
      e.carry = 1'b0;
      e.sel   = 2'b01;
      e.led   = 7'b000_0000;
      sb_q.push_back(e);
   endtask

   initial begin
      seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      enable   = 1'b0;
      clear    = 1'b0;
      up_down  = 1'b1;
      model_reset();

      #2;
      push_reset_exp();
      compare_out("reset");
      #1;
      reset = 1'b0;

      // Count up 40 cycles: ten ticks, BCD never shows 0A.
      enable = 1'b1;
      repeat (40) cyc();
      chk("up40_bcd", 32'(bcd_out), 32'h10);

      // Up to 99, then wrap.
      repeat (89 * 4) cyc();
      chk("at99_bcd", 32'(bcd_out), 32'h99);
      repeat (4) cyc();
      chk("wrap_up_bcd", 32'(bcd_out), 32'h00);
      chk("wrap_up_carry", 32'(carry_out), 32'd1);
      cyc();
      chk("wrap_up_pulse1", 32'(carry_out), 32'd0);

      // Count down from 00.
      up_down = 1'b0;
      for (int i = 0; i < 8 && m_cnt == 0; i++) cyc();
      chk("wrap_dn_bcd", 32'(bcd_out), 32'h99);
      chk("wrap_dn_carry", 32'(carry_out), 32'd1);
      repeat (4) cyc();
      chk("dn98_bcd", 32'(bcd_out), 32'h98);
      chk("dn98_carry", 32'(carry_out), 32'd0);

      // Clear exactly when a tick is due.
      up_down = 1'b1;
      for (int i = 0; i < 8 && m_presc != 3; i++) cyc();
      chk("pre_clear_presc", 32'(m_presc), 32'd3);
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      chk("clear_bcd", 32'(bcd_out), 32'h00);
      chk("clear_carry", 32'(carry_out), 32'd0);
      repeat (3) cyc();
      chk("clear_hold_bcd", 32'(bcd_out), 32'h00);
      cyc();
      chk("clear_restart_bcd", 32'(bcd_out), 32'h01);

      // Scan at 07 with the count frozen.
      repeat (6 * 4) cyc();
      chk("at07_bcd", 32'(bcd_out), 32'h07);
      enable = 1'b0;
      repeat (8) cyc();

      // Up to 35, hold with enable low.
      enable = 1'b1;
      repeat (28 * 4) cyc();
      chk("at35_bcd", 32'(bcd_out), 32'h35);
      enable = 1'b0;
      repeat (20) cyc();
      chk("hold35_bcd", 32'(bcd_out), 32'h35);

      // Asynchronous reset mid-count.
      enable = 1'b1;
      repeat (2) cyc();
      #2;
      reset = 1'b1;
      #1;
      push_reset_exp();
      compare_out("async_rst");
      model_reset();
      #2;
      reset = 1'b0;
      repeat (12) cyc();
      chk("post_rst_bcd", 32'(bcd_out), 32'h03);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
